inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 117 +++++++++++
 tb/tb_inst_fetch_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// Circular instruction queue between the fetch and decode stages. Each entry
// holds the fetch PC, the instruction word, the fetch exception vector and the
// delay-slot flag. A pushed entry can be popped one cycle later at the
// earliest; there is no bypass around an empty queue.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   flush_i           : drop every queued entry at the next edge; overrides push/pop
//   push_valid_i      : fetch offers an entry
//   push_ready_o      : queue not full (independent of pop_ready_i)
//   push_*_i          : entry fields (pc, instr, except, dslot)
//   pop_ready_i       : decode consumes the head entry
//   pop_valid_o       : queue not empty
//   pop_*_o           : head entry fields, forced to 0 while empty
//   count_o           : current occupancy, 0..DEPTH
//   almost_full_o     : count_o >= AF_LEVEL
module inst_fetch_queue #(
  parameter int DEPTH    = 8,
  parameter int EXC_W    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [31:0]              push_pc_i,
  input  logic [31:0]              push_instr_i,
  input  logic [EXC_W-1:0]         push_except_i,
  input  logic                     push_dslot_i,
  input  logic                     pop_ready_i,
  output logic                     pop_valid_o,
  output logic [31:0]              pop_pc_o,
  output logic [31:0]              pop_instr_o,
  output logic [EXC_W-1:0]         pop_except_o,
  output logic                     pop_dslot_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     almost_full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Entry storage is deliberately left without reset; the counter alone
  // decides which entries are meaningful.
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [EXC_W-1:0] exc_mem_q   [DEPTH];
  logic             dslot_mem_q [DEPTH];

  logic push_fire;
  logic pop_fire;

  assign push_ready_o = (count_q != FULL_CNT);
  assign pop_valid_o  = (count_q != '0);
  assign push_fire    = push_valid_i && push_ready_o;
  assign pop_fire     = pop_valid_o && pop_ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire && !flush_i) begin
      pc_mem_q[wr_ptr_q]    <= push_pc_i;
      instr_mem_q[wr_ptr_q] <= push_instr_i;
      exc_mem_q[wr_ptr_q]   <= push_except_i;
      dslot_mem_q[wr_ptr_q] <= push_dslot_i;
    end
  end

  // Empty queue presents an all-zero head so decode sees a NOP and never
  // reads unwritten storage.
  assign pop_pc_o      = pop_valid_o ? pc_mem_q[rd_ptr_q]    : '0;
  assign pop_instr_o   = pop_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign pop_except_o  = pop_valid_o ? exc_mem_q[rd_ptr_q]   : '0;
  assign pop_dslot_o   = pop_valid_o ? dslot_mem_q[rd_ptr_q] : 1'b0;

  assign count_o       = count_q;
  assign almost_full_o = (count_q >= AF_CNT);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed scenarios with literal expectations
// plus a queue-based reference model compared against the DUT every cycle.
module tb_inst_fetch_queue;

  localparam int DEPTH = 8;
  localparam int EXC_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        push_valid_i = 1'b0;
  logic        push_ready_o;
  logic [31:0] push_pc_i = '0;
  logic [31:0] push_instr_i = '0;
  logic [7:0]  push_except_i = '0;
  logic        push_dslot_i = 1'b0;
  logic        pop_ready_i = 1'b0;
  logic        pop_valid_o;
  logic [31:0] pop_pc_o;
  logic [31:0] pop_instr_o;
  logic [7:0]  pop_except_o;
  logic        pop_dslot_o;
  logic [3:0]  count_o;
  logic        almost_full_o;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_pc_i(push_pc_i), .push_instr_i(push_instr_i),
    .push_except_i(push_except_i), .push_dslot_i(push_dslot_i),
    .pop_ready_i(pop_ready_i), .pop_valid_o(pop_valid_o),
    .pop_pc_o(pop_pc_o), .pop_instr_o(pop_instr_o),
    .pop_except_o(pop_except_o), .pop_dslot_o(pop_dslot_o),
    .count_o(count_o), .almost_full_o(almost_full_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  exc;
    logic        dslot;
  } ent_t;

  ent_t mq[$];
  ent_t m_new;
  bit   m_pop, m_push;

  function automatic ent_t mk(logic [31:0] pc);
    ent_t e;
    e.pc    = pc;
    e.instr = pc ^ 32'h1357_9BDF;
    e.exc   = pc[9:2];
    e.dslot = pc[2];
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of entries updated with the queue rules.
  always @(posedge clk or posedge rst) begin
    if (rst || flush_i) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() > 0) && pop_ready_i;
      m_push = push_valid_i && (mq.size() < DEPTH);
      m_new.pc    = push_pc_i;
      m_new.instr = push_instr_i;
      m_new.exc   = push_except_i;
      m_new.dslot = push_dslot_i;
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(m_new);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    ent_t h;
    int   n;
    n = mq.size();
    h.pc = '0; h.instr = '0; h.exc = '0; h.dslot = 1'b0;
    if (n > 0) h = mq[0];
    chk("m_count", 64'(count_o), 64'(n));
    chk("m_pop_valid", 64'(pop_valid_o), 64'(n != 0));
    chk("m_push_ready", 64'(push_ready_o), 64'(n != DEPTH));
    chk("m_almost_full", 64'(almost_full_o), 64'(n >= DEPTH - 2));
    chk("m_pop_pc", 64'(pop_pc_o), 64'(h.pc));
    chk("m_pop_instr", 64'(pop_instr_o), 64'(h.instr));
    chk("m_pop_except", 64'(pop_except_o), 64'(h.exc));
    chk("m_pop_dslot", 64'(pop_dslot_o), 64'(h.dslot));
  end

  task automatic drive(bit pv, logic [31:0] pc, bit pr, bit fl);
    ent_t e;
    e = mk(pc);
    push_valid_i  = pv;
    push_pc_i     = e.pc;
    push_instr_i  = e.instr;
    push_except_i = e.exc;
    push_dslot_i  = e.dslot;
    pop_ready_i   = pr;
    flush_i       = fl;
  endtask

  task automatic cyc(bit pv, logic [31:0] pc, bit pr, bit fl);
    drive(pv, pc, pr, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_count"}, 64'(count_o), 64'd0);
    chk({tag, "_pop_valid"}, 64'(pop_valid_o), 64'd0);
    chk({tag, "_push_ready"}, 64'(push_ready_o), 64'd1);
    chk({tag, "_almost_full"}, 64'(almost_full_o), 64'd0);
    chk({tag, "_pop_pc"}, 64'(pop_pc_o), 64'd0);
    chk({tag, "_pop_instr"}, 64'(pop_instr_o), 64'd0);
    chk({tag, "_pop_except"}, 64'(pop_except_o), 64'd0);
    chk({tag, "_pop_dslot"}, 64'(pop_dslot_o), 64'd0);
  endtask

  initial begin
    drive(0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst_init");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Three pushes with decode stalled.
    cyc(1, 32'hBFC0_0000, 0, 0);
    cyc(1, 32'hBFC0_0004, 0, 0);
    cyc(1, 32'hBFC0_0008, 0, 0);
    chk("boot_count", 64'(count_o), 64'd3);
    chk("boot_head_pc", 64'(pop_pc_o), 64'hBFC0_0000);
    chk("boot_pop_valid", 64'(pop_valid_o), 64'd1);

    // Fill to DEPTH, watching almost-full rise at 6.
    for (int i = 3; i < 8; i++) begin
      cyc(1, 32'hBFC0_0000 + 32'(4 * i), 0, 0);
      chk("fill_count", 64'(count_o), 64'(i + 1));
      chk("fill_af", 64'(almost_full_o), 64'(i + 1 >= 6));
    end
    chk("full_push_ready", 64'(push_ready_o), 64'd0);
    cyc(1, 32'hAAAA_0000, 0, 0);
    chk("ninth_push_count", 64'(count_o), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 64'(pop_pc_o), 64'(32'hBFC0_0000 + 32'(4 * i)));
      cyc(0, 32'h0, 1, 0);
    end
    chk("drain_empty", 64'(pop_valid_o), 64'd0);

    // Streaming: occupancy constant, pointers wrap three times.
    for (int i = 0; i < 3; i++) cyc(1, 32'h1000 + 32'(4 * i), 0, 0);
    for (int k = 0; k < 3 * DEPTH; k++) begin
      chk("stream_head", 64'(pop_pc_o), 64'(32'h1000 + 32'(4 * k)));
      chk("stream_count", 64'(count_o), 64'd3);
      cyc(1, 32'h1000 + 32'(4 * (k + 3)), 1, 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 32'h0, 1, 0);
    chk("stream_drained", 64'(count_o), 64'd0);

    // Flush wins over a same-cycle push and pop.
    for (int i = 0; i < 5; i++) cyc(1, 32'h2000 + 32'(4 * i), 0, 0);
    chk("pre_flush_count", 64'(count_o), 64'd5);
    cyc(1, 32'hDEAD_0000, 1, 1);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_pop_valid", 64'(pop_valid_o), 64'd0);
    chk("flush_pop_instr", 64'(pop_instr_o), 64'd0);
    cyc(1, 32'h3000, 0, 0);
    chk("post_flush_count", 64'(count_o), 64'd1);
    chk("post_flush_head", 64'(pop_pc_o), 64'h3000);

    // Asynchronous reset pulse between edges with four entries queued.
    for (int i = 1; i < 4; i++) cyc(1, 32'h3000 + 32'(4 * i), 0, 0);
    chk("pre_rst_count", 64'(count_o), 64'd4);
    drive(0, 32'h0, 0, 0);
    #1 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 32'h4000, 0, 0);
    chk("post_rst_count", 64'(count_o), 64'd1);
    chk("post_rst_head", 64'(pop_pc_o), 64'h4000);
    cyc(0, 32'h0, 1, 0);

    // Full queue with push and pop together: only the pop happens.
    for (int i = 0; i < 8; i++) cyc(1, 32'h5000 + 32'(4 * i), 0, 0);
    cyc(1, 32'hEEEE_0000, 1, 0);
    chk("full_pp_count", 64'(count_o), 64'd7);
    chk("full_pp_head", 64'(pop_pc_o), 64'h5004);
    for (int i = 1; i < 8; i++) begin
      chk("full_pp_order", 64'(pop_pc_o), 64'(32'h5000 + 32'(4 * i)));
      cyc(0, 32'h0, 1, 0);
    end
    chk("full_pp_empty", 64'(count_o), 64'd0);

    // Mixed traffic checked by the model alone.
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) == 0,
          $urandom_range(0, 24) == 0);
    end

    drive(0, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
